// File: rtl/fetch_stage.sv
// MIPS32 instruction-fetch stage: owns the PC, runs the ready-based imem handshake
// and loads the IF/ID register, inserting bubbles on stalls, waits and redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        IF_IDWrite,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic [31:0] PC
);

  // state    | meaning
  // S_FETCH  | request outstanding at PC, result goes straight to IF/ID
  // S_HOLD   | fetched word parked in hbuf while ID is stalled
  // S_REDIR  | redirect seen mid-request; wait for the old request, then jump to ptgt
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_REDIR = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_hbuf, w_hbuf_nxt;
  logic [31:0] r_ptgt, w_ptgt_nxt;
  logic [31:0] r_instr, r_pcplus4;
  logic        r_valid;

  logic        w_advance;
  logic        w_deliver;
  logic [31:0] w_dinstr;
  logic [31:0] w_pcplus4;

  assign w_advance = PCWrite & IF_IDWrite;
  assign w_pcplus4 = r_pc + 32'd4;

  // Request lines depend only on state and PC so the address stays stable mid-handshake.
  assign IMemReq  = (r_state != S_HOLD);
  assign IMemAddr = r_pc;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_hbuf_nxt  = r_hbuf;
    w_ptgt_nxt  = r_ptgt;
    w_deliver   = 1'b0;
    w_dinstr    = IMemData;
    case (r_state)
      S_FETCH: begin
        if (IMemReady) begin
          if (BranchTaken) begin
            w_pc_nxt = BranchTarget;
          end else if (w_advance) begin
            w_deliver = 1'b1;
            w_pc_nxt  = w_pcplus4;
          end else begin
            w_hbuf_nxt  = IMemData;
            w_state_nxt = S_HOLD;
          end
        end else if (BranchTaken) begin
          w_ptgt_nxt  = BranchTarget;
          w_state_nxt = S_REDIR;
        end
      end
      S_HOLD: begin
        w_dinstr = r_hbuf;
        if (BranchTaken) begin
          w_pc_nxt    = BranchTarget;
          w_state_nxt = S_FETCH;
        end else if (w_advance) begin
          w_deliver   = 1'b1;
          w_pc_nxt    = w_pcplus4;
          w_state_nxt = S_FETCH;
        end
      end
      S_REDIR: begin
        if (BranchTaken) begin
          w_ptgt_nxt = BranchTarget;
        end
        if (IMemReady) begin
          w_pc_nxt    = BranchTaken ? BranchTarget : r_ptgt;
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_hbuf  <= 32'd0;
      r_ptgt  <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_hbuf  <= w_hbuf_nxt;
      r_ptgt  <= w_ptgt_nxt;
    end
  end

  // A redirect flushes IF/ID even when the hazard unit is stalling.
  always_ff @(posedge clk) begin
    if (rst || BranchTaken) begin
      r_instr   <= 32'd0;
      r_pcplus4 <= 32'd0;
      r_valid   <= 1'b0;
    end else if (w_advance) begin
      if (w_deliver) begin
        r_instr   <= w_dinstr;
        r_pcplus4 <= w_pcplus4;
        r_valid   <= 1'b1;
      end else begin
        r_instr   <= 32'd0;
        r_pcplus4 <= 32'd0;
        r_valid   <= 1'b0;
      end
    end
  end

  assign IF_ID_Instr   = r_instr;
  assign IF_ID_PCPlus4 = r_pcplus4;
  assign IF_ID_Valid   = r_valid;
  assign PC            = r_pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a transaction-level fetch model predicts the
// request lines each cycle and the IF/ID contents after each edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCWrite, IF_IDWrite, BranchTaken;
  logic [31:0] BranchTarget;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady;
  logic [31:0] IMemData;
  logic [31:0] IF_ID_Instr, IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic [31:0] PC;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .IF_IDWrite(IF_IDWrite),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemReady(IMemReady), .IMemData(IMemData),
    .IF_ID_Instr(IF_ID_Instr), .IF_ID_PCPlus4(IF_ID_PCPlus4), .IF_ID_Valid(IF_ID_Valid),
    .PC(PC)
  );

  always #5 clk = ~clk;

  // Model: a parked word, a pending redirect, or neither.
  logic [31:0] m_pc, m_buf, m_ptgt, m_instr, m_pc4;
  bit          m_parked, m_redir, m_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_buf = 32'h0; m_ptgt = 32'h0;
    m_parked = 0; m_redir = 0;
    m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 0;
  endtask

  task automatic model_edge(input bit adv, input bit rdy, input bit bt,
                            input logic [31:0] tgt, input logic [31:0] data);
    bit          got = 0;
    logic [31:0] word = 32'h0;
    logic [31:0] nxt = m_pc + 32'd4;
    if (m_parked) begin
      if (bt) begin m_pc = tgt; m_parked = 0; end
      else if (adv) begin got = 1; word = m_buf; m_parked = 0; end
    end else if (m_redir) begin
      if (rdy) begin m_pc = bt ? tgt : m_ptgt; m_redir = 0; end
      else if (bt) m_ptgt = tgt;
    end else if (rdy) begin
      if (bt) m_pc = tgt;
      else if (adv) begin got = 1; word = data; end
      else begin m_buf = data; m_parked = 1; end
    end else if (bt) begin
      m_ptgt = tgt; m_redir = 1;
    end
    if (got) m_pc = nxt;
    if (bt || (adv && !got)) begin
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 0;
    end else if (adv) begin
      m_instr = word; m_pc4 = nxt; m_valid = 1;
    end
  endtask

  // One clock: drive at negedge, check request side, clock it, check IF/ID.
  task automatic cycle(input bit r, input bit adv, input bit rdy, input bit bt,
                       input logic [31:0] tgt, input bit addr_data);
    @(negedge clk);
    rst = r; PCWrite = adv; IF_IDWrite = adv; IMemReady = rdy;
    BranchTaken = bt; BranchTarget = tgt;
    IMemData = addr_data ? (IMemAddr | 32'd1) : $urandom;
    #1;
    chk("imem_req", {31'd0, IMemReq}, {31'd0, !m_parked});
    chk("imem_addr", IMemAddr, m_pc);
    chk("pc", PC, m_pc);
    if (r) model_reset();
    else model_edge(adv, rdy, bt, tgt, IMemData);
    @(posedge clk); #1;
    chk("ifid_instr", IF_ID_Instr, m_instr);
    chk("ifid_pc4", IF_ID_PCPlus4, m_pc4);
    chk("ifid_valid", {31'd0, IF_ID_Valid}, {31'd0, m_valid});
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 3))
      0: return 32'hFFFF_FFFC;
      1: return 32'hFFFF_FFF8;
      default: return {$urandom_range(0, 32'h3FFF), 2'b00};
    endcase
  endfunction

  initial begin
    rst = 1; PCWrite = 1; IF_IDWrite = 1; BranchTaken = 0; BranchTarget = 0;
    IMemReady = 1; IMemData = 0;
    repeat (2) @(posedge clk);
    model_reset();
    cycle(1, 1, 1, 0, 32'h0, 1);
    chk("rst_valid", {31'd0, IF_ID_Valid}, 32'd0);
    chk("rst_pc", PC, 32'h0);

    // Zero-wait streaming from reset.
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 1, 0, 32'h0, 1);
      chk("seq_instr", IF_ID_Instr, 32'(4 * i + 1));
      chk("seq_pc4", IF_ID_PCPlus4, 32'(4 * i + 4));
    end

    // Load-use stall for two cycles while fetching 12, then release.
    cycle(0, 0, 1, 0, 32'h0, 1);
    cycle(0, 0, 1, 0, 32'h0, 1);
    chk("stall_req", {31'd0, IMemReq}, 32'd0);
    chk("stall_pc", PC, 32'd12);
    chk("stall_hold", IF_ID_Instr, 32'd9);
    cycle(0, 1, 0, 0, 32'h0, 1);
    chk("release_instr", IF_ID_Instr, 32'd13);
    chk("release_addr", IMemAddr, 32'd16);

    // Wait with two redirects: newest target wins after the old request completes.
    cycle(0, 1, 0, 1, 32'h200, 1);
    cycle(0, 1, 0, 1, 32'h300, 1);
    cycle(0, 1, 1, 0, 32'h0, 1);
    chk("redir_addr", IMemAddr, 32'h300);
    chk("redir_valid", {31'd0, IF_ID_Valid}, 32'd0);

    // Redirect while holding a parked word under stall.
    cycle(0, 0, 1, 0, 32'h0, 1);
    cycle(0, 0, 0, 1, 32'h40, 1);
    chk("hold_flush", {31'd0, IF_ID_Valid}, 32'd0);
    chk("hold_addr", IMemAddr, 32'h40);

    // Reset while a redirect is pending.
    cycle(0, 1, 0, 1, 32'h800, 1);
    cycle(1, 1, 0, 0, 32'h0, 1);
    chk("redir_rst_pc", PC, 32'h0);

    // Wrap from the top of the address space.
    cycle(0, 1, 1, 1, 32'hFFFF_FFFC, 1);
    cycle(0, 1, 1, 0, 32'h0, 1);
    chk("wrap_pc4", IF_ID_PCPlus4, 32'h0);
    chk("wrap_addr", IMemAddr, 32'h0);

    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 70),
            ($urandom_range(0, 99) < 65), ($urandom_range(0, 99) < 15),
            pick_target(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
